// File: rtl/piton_dcr_fifo_pkg.sv
// piton_dcr_fifo_pkg: shared DCR FIFO defaults and sizing helpers
package piton_dcr_fifo_pkg;
  localparam int VX_DCR_ADDR_WIDTH = 8;
  localparam int VX_DCR_DATA_WIDTH = 32;
  localparam int DCR_FIFO_DEPTH_LOG2 = 3;
  localparam int DCR_HOLD_CYCLES = 3;
  localparam int DCR_SYNC_STAGES = 2;
  function automatic int hold_width(input int cycles);
    return cycles > 1 ? $clog2(cycles) : 1;
  endfunction
endpackage

// File: rtl/piton_sync_nstage.sv
// piton_sync_nstage: n-flop single-bit synchroniser with async reset to 0
module piton_sync_nstage #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s <= '0;
    else begin
      s[0] <= d;
      for (int i = 1; i < STAGES; i++) s[i] <= s[i-1];
    end
  end
  assign q = s[STAGES-1];
endmodule

// File: rtl/piton_dcr_fifo.sv
// piton_dcr_fifo: DCR write FIFO holding each entry for HOLD_CYCLES ready cycles
module piton_dcr_fifo
  import piton_dcr_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = VX_DCR_ADDR_WIDTH,
  parameter int DATA_WIDTH = VX_DCR_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DCR_FIFO_DEPTH_LOG2,
  parameter int HOLD_CYCLES = DCR_HOLD_CYCLES,
  parameter int SYNC_STAGES = DCR_SYNC_STAGES,
  parameter int AFULL_THRESH = (1 << DEPTH_LOG2) - 2,
  parameter bit BYPASS_EN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  flush,
  input  logic                  ovf_clear,
  input  logic                  vx_rdy,
  output logic                  dcr_wr_valid,
  output logic [ADDR_WIDTH-1:0] dcr_wr_addr,
  output logic [DATA_WIDTH-1:0] dcr_wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int HW = hold_width(HOLD_CYCLES);
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic [HW-1:0] hold;
  logic rdy_q, byp, pop, push, drop;
  piton_sync_nstage #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(vx_rdy), .q(rdy_q));
  assign count = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign almost_full = 32'(count) >= 32'(AFULL_THRESH);
  // An empty FIFO shows the incoming write directly when bypass is built in
  assign byp = BYPASS_EN && empty && wr_valid;
  assign dcr_wr_valid = rdy_q && (!empty || byp);
  assign dcr_wr_addr = byp ? wr_addr : addr_mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign dcr_wr_data = byp ? wr_data : data_mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign pop = dcr_wr_valid && (hold == HW'(HOLD_CYCLES - 1));
  assign push = wr_valid && (!full || pop);
  assign drop = wr_valid && full && !pop;
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      addr_mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_addr;
      data_mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (dcr_wr_valid) hold <= pop ? '0 : hold + 1'b1;
      overflow <= drop || (overflow && !ovf_clear);
    end
  end
endmodule

// File: tb/tb_piton_dcr_fifo.sv
// tb_piton_dcr_fifo: queue-model bench for the DCR write FIFO plus a bypass build
module tb_piton_dcr_fifo;
  localparam int DEPTH = 8;
  localparam int HOLD = 3;
  localparam int SYNC = 2;
  localparam int AF = 6;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic wr_valid = 0, flush = 0, ovf_clear = 0, vx_rdy = 0;
  logic [7:0] wr_addr = 0;
  logic [31:0] wr_data = 0;
  logic dcr_wr_valid, full, almost_full, empty, overflow;
  logic [7:0] dcr_wr_addr;
  logic [31:0] dcr_wr_data;
  logic [3:0] count;
  logic b_wr_valid = 0, b_vx_rdy = 1;
  logic [7:0] b_wr_addr = 0;
  logic [31:0] b_wr_data = 0;
  logic b_valid, b_full, b_af, b_empty, b_ovf;
  logic [7:0] b_addr;
  logic [31:0] b_data;
  logic [3:0] b_count;
  piton_dcr_fifo u_dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush), .ovf_clear(ovf_clear), .vx_rdy(vx_rdy), .dcr_wr_valid(dcr_wr_valid),
    .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data), .full(full),
    .almost_full(almost_full), .empty(empty), .count(count), .overflow(overflow)
  );
  piton_dcr_fifo #(.BYPASS_EN(1'b1), .HOLD_CYCLES(1)) u_byp (
    .clk(clk), .rst(rst), .wr_valid(b_wr_valid), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .flush(1'b0), .ovf_clear(1'b0), .vx_rdy(b_vx_rdy), .dcr_wr_valid(b_valid),
    .dcr_wr_addr(b_addr), .dcr_wr_data(b_data), .full(b_full),
    .almost_full(b_af), .empty(b_empty), .count(b_count), .overflow(b_ovf)
  );
  int nvec = 0, nerr = 0;
  int vc [256];
  typedef struct packed {logic [7:0] a; logic [31:0] d;} ent_t;
  ent_t q [$];
  int m_hold = 0;
  bit m_ovf = 0;
  bit hist [$];
  function automatic bit m_rq();
    return hist.size() >= SYNC ? hist[SYNC-1] : 1'b0;
  endfunction
  function automatic bit m_valid();
    return m_rq() && q.size() > 0;
  endfunction
  function automatic bit m_pop();
    return m_valid() && m_hold == HOLD - 1;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic compare();
    if (dcr_wr_valid === 1'b1) vc[dcr_wr_addr]++;
    chk("valid", dcr_wr_valid, m_valid());
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("almost_full", almost_full, q.size() >= AF);
    chk("overflow", overflow, m_ovf);
    if (m_valid()) begin
      chk("addr", dcr_wr_addr, q[0].a);
      chk("data", dcr_wr_data, q[0].d);
    end
  endtask
  task automatic model_step();
    bit v, p, drop;
    v = m_valid();
    p = m_pop();
    if (flush) begin
      q.delete();
      m_hold = 0;
      m_ovf = 0;
    end else begin
      drop = wr_valid && q.size() == DEPTH && !p;
      if (v) m_hold = p ? 0 : m_hold + 1;
      if (p) void'(q.pop_front());
      if (wr_valid && !drop) q.push_back({wr_addr, wr_data});
      m_ovf = drop || (m_ovf && !ovf_clear);
    end
    hist.push_front(vx_rdy);
    if (hist.size() > 4) void'(hist.pop_back());
  endtask
  task automatic model_reset();
    q.delete();
    m_hold = 0;
    m_ovf = 0;
    hist.delete();
  endtask
  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic push(input logic [7:0] a, input logic [31:0] d);
    wr_valid = 1;
    wr_addr = a;
    wr_data = d;
    cycle();
    wr_valid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) cycle();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    for (int i = 0; i < 256; i++) vc[i] = 0;
    vx_rdy = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", dcr_wr_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    model_reset();
    rst = 0;
    push(8'h10, 32'hAAAA0001);
    push(8'h11, 32'hAAAA0002);
    idle(10);
    chk("t1_hold10", vc[8'h10], 3);
    chk("t1_hold11", vc[8'h11], 3);
    chk("t1_empty", empty, 1);
    vx_rdy = 0;
    idle(3);
    for (int i = 0; i < 9; i++) begin
      push(8'h30 + 8'(i), 32'hB000_0000 + 32'(i));
      if (i == 4) chk("t2_af_at5", almost_full, 0);
      if (i == 5) chk("t2_af_at6", almost_full, 1);
      if (i == 7) chk("t2_full", full, 1);
    end
    chk("t2_ovf", overflow, 1);
    chk("t2_count", count, 8);
    vx_rdy = 1;
    idle(30);
    chk("t2_first", vc[8'h30], 3);
    chk("t2_eighth", vc[8'h37], 3);
    chk("t2_dropped", vc[8'h38], 0);
    ovf_clear = 1;
    cycle();
    ovf_clear = 0;
    chk("t2_ovf_clear", overflow, 0);
    wr_valid = 1;
    wr_addr = 8'h40;
    wr_data = 32'hC0C0_0040;
    vx_rdy = 0;
    cycle();
    wr_valid = 0;
    idle(3);
    chk("t3_frozen_valid", dcr_wr_valid, 0);
    chk("t3_frozen_count", count, 1);
    vx_rdy = 1;
    idle(8);
    chk("t3_hold", vc[8'h40], 3);
    vx_rdy = 0;
    idle(3);
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i), $urandom);
    chk("t4_full", full, 1);
    vx_rdy = 1;
    n = 0;
    for (int k = 0; k < 200 && n < 20; k++) begin
      if (m_pop()) begin
        wr_valid = 1;
        wr_addr = 8'h60 + 8'(n);
        wr_data = $urandom;
        n++;
      end
      cycle();
      wr_valid = 0;
    end
    chk("t4_pairs", n, 20);
    chk("t4_count", count, 8);
    chk("t4_ovf", overflow, 0);
    idle(30);
    chk("t4_last", vc[8'h73], 3);
    chk("t4_drained", count, 0);
    vx_rdy = 0;
    idle(3);
    for (int i = 0; i < 4; i++) push(8'h90 + 8'(i), 32'hD000_0000 + 32'(i));
    flush = 1;
    wr_valid = 1;
    wr_addr = 8'h9F;
    wr_data = 32'hDEAD_BEEF;
    cycle();
    flush = 0;
    wr_valid = 0;
    chk("t5_count", count, 0);
    chk("t5_valid", dcr_wr_valid, 0);
    chk("t5_ovf", overflow, 0);
    vx_rdy = 1;
    idle(10);
    chk("t5_flushed_wr", vc[8'h9F], 0);
    chk("t5_flushed_q", vc[8'h90], 0);
    b_wr_valid = 1;
    b_wr_addr = 8'h20;
    b_wr_data = 32'h1234_5678;
    #1;
    chk("t6_byp_valid", b_valid, 1);
    chk("t6_byp_addr", b_addr, 8'h20);
    chk("t6_byp_data", b_data, 32'h1234_5678);
    chk("t6_byp_count", b_count, 0);
    cycle();
    b_wr_valid = 0;
    #1;
    chk("t6_byp_count_after", b_count, 0);
    chk("t6_byp_empty", b_empty, 1);
    chk("t6_byp_idle", b_valid, 0);
    push(8'h80, 32'hE000_0080);
    cycle();
    #2;
    rst = 1;
    #1;
    chk("t7_valid", dcr_wr_valid, 0);
    chk("t7_empty", empty, 1);
    chk("t7_count", count, 0);
    chk("t7_full", full, 0);
    chk("t7_af", almost_full, 0);
    chk("t7_ovf", overflow, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    idle(6);
    chk("t7_lost", vc[8'h80], 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
